lcd_driver: RTL
===============

# lcd_driver

Timing generator for the parallel RGB LCD path. It produces horizontal/vertical sync, data-enable and pixel coordinates from free-running counters on `lcd_pclk`. It requests pixel data one clock early from the downstream-of-timing pattern/display stage, which registers `pixel_data` with one cycle of latency. It then gates the returned colour onto the panel bus aligned to `lcd_de`.

## Interface
Parameters:
- `H_BACK`, 88, horizontal back porch (clocks)
- `H_DISP`, 800, active pixels per line
- `H_FRONT`, 40, horizontal front porch
- `H_SYNC`, 128, hsync pulse width
- `V_BACK`, 33, vertical back porch (lines)
- `V_DISP`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width

Ports:
- `lcd_pclk`  in  1  pixel clock; sole clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `pixel_data`  in  24  RGB888 from display stage, valid one clock after `pixel_xpos`/`pixel_ypos`
- `pixel_xpos`  out  11  requested pixel column
- `pixel_ypos`  out  11  requested pixel row
- `h_disp`  out  11  constant `H_DISP`
- `v_disp`  out  11  constant `V_DISP`
- `data_req`  out  1  coordinates valid, one clock ahead of `lcd_de`
- `lcd_hs`  out  1  hsync, active-low
- `lcd_vs`  out  1  vsync, active-low
- `lcd_de`  out  1  data enable, active-high
- `lcd_rgb`  out  24  panel colour bus
- `frame_cnt`  out  16  completed-frame count (see Configuration)

## Operation
- Derived constants:
  - `H_TOTAL = H_BACK + H_DISP + H_FRONT + H_SYNC` (default 1056).
  - `V_TOTAL = V_BACK + V_DISP + V_FRONT + V_SYNC` (default 525).
  - Both must be ≤ 2048.
  - `H_BACK ≥ 1`, `V_BACK ≥ 1`.
- Counters:
  - `h_cnt` (11 b) increments every clock and wraps from `H_TOTAL-1` to 0.
  - `v_cnt` (11 b) increments only on `h_cnt` wrap.
  - `v_cnt` wraps from `V_TOTAL-1` to 0 on the same edge as the `h_cnt` wrap.
- Line order is back porch, active, front porch, sync. Frame order is the same in lines.
- Decode (combinational from registered counters):
  - Line active window: `h_act` = `H_BACK ≤ h_cnt < H_BACK+H_DISP`.
  - Line request window: `h_req` = `H_BACK-1 ≤ h_cnt < H_BACK+H_DISP-1`.
  - Frame active window: `v_act` = `V_BACK ≤ v_cnt < V_BACK+V_DISP`.
  - `lcd_hs` = 0 iff `h_cnt ≥ H_TOTAL-H_SYNC`.
  - `lcd_vs` = 0 iff `v_cnt ≥ V_TOTAL-V_SYNC`.
  - `lcd_de` = `h_act & v_act`.
  - `data_req` = `h_req & v_act`.
  - `pixel_xpos` = `h_cnt-(H_BACK-1)` when `data_req`, else 0.
  - `pixel_ypos` = `v_cnt-V_BACK` when `v_act`, else 0.
  - `lcd_rgb` = `pixel_data` when `lcd_de`, else 24'h0.
- Arithmetic is unsigned 11-bit. Subtractions are evaluated only inside their windows, so they never underflow at the output.
- `h_disp`/`v_disp` are constants, independent of reset.

## Timing
- Reset (`rst` high at an edge):
  - `h_cnt`, `v_cnt` and `frame_cnt` go to 0.
  - Outputs then read: `lcd_hs`=1, `lcd_vs`=1, `lcd_de`=0, `data_req`=0, `pixel_xpos`=0, `pixel_ypos`=0, `lcd_rgb`=0.
  - This holds for every clock while `rst` is high.
- Reset mid-frame: the counters restart at 0 on that edge with no completion of the current line. The first clock after release is line 0, column 0.
- `data_req` rises one clock before `lcd_de` and falls one clock before it. The `pixel_xpos` sequence is 0…H_DISP-1.
- The display stage's registered `pixel_data` for column N appears on `lcd_rgb` while `lcd_de` is high and `h_cnt = H_BACK+N`. Total request-to-panel latency is 1 clock.
- Per line: `lcd_de` is high for exactly `H_DISP` clocks and `lcd_hs` is low for exactly `H_SYNC` clocks.
- Per frame:
  - `lcd_vs` is low for `V_SYNC*H_TOTAL` clocks.
  - `v_act` covers `V_DISP` lines.
  - The frame period is `H_TOTAL*V_TOTAL` clocks (default 554400).
- Simultaneous h and v wrap: both counters go to 0 on the same edge, and no glitch line is inserted.

## Configuration
- `LCD_FRAME_CNT_EN` defined:
  - `frame_cnt` increments by 1 on each edge where both `h_cnt` and `v_cnt` wrap.
  - It wraps from 16'hFFFF to 0.
  - It is cleared by `rst`.
- Not defined:
  - `frame_cnt` is tied to 16'h0 and no counter register is built.
  - The port remains so the interface is identical.

## Test plan
- **Reset:**
  - Stimulus: hold `rst` for 5 clocks.
  - Required: throughout, `lcd_hs`=1, `lcd_vs`=1, `lcd_de`=0, `data_req`=0, `lcd_rgb`=0.
  - Required: first active `lcd_de` edge occurs 33·1056+88 = 34936 clocks after release.
- **Line timing (defaults):**
  - Required: `lcd_de` high 800 clocks and `lcd_hs` low 128 clocks per line.
  - Required: rising edges of `lcd_hs` are 1056 clocks apart.
- **Request alignment:**
  - Stimulus: drive `pixel_data` = {13'b0, `pixel_xpos`} registered one clock.
  - Required: while `lcd_de`=1, `lcd_rgb[10:0]` steps 0…799 without skip.
  - Required: `data_req` leads `lcd_de` by exactly 1 clock at both edges.
- **Frame timing:**
  - Required: `lcd_vs` low for 2112 clocks.
  - Required: `pixel_ypos` spans 0…479 across active lines.
  - Required: `lcd_vs` falling edges are 554400 clocks apart.
- **Mid-frame reset:**
  - Stimulus: assert `rst` for 1 clock at line 200, column 400.
  - Required: next clock `lcd_de`=0, `pixel_ypos`=0, `lcd_hs`=1.
  - Required: the timing sequence restarts from frame start.
- **`LCD_FRAME_CNT_EN`:**
  - Defined: after 3 full frames `frame_cnt`=3.
  - Undefined: `frame_cnt` stays 0.

Source files
------------

// File: rtl/lcd_driver.sv
// lcd_driver: parallel RGB LCD timing generator (hsync/vsync/DE, pixel request, colour gating).
// Optional: define LCD_FRAME_CNT_EN to build the completed-frame counter behind frame_cnt.
module lcd_driver #(
    parameter int unsigned H_BACK  = 32'd88,
    parameter int unsigned H_DISP  = 32'd800,
    parameter int unsigned H_FRONT = 32'd40,
    parameter int unsigned H_SYNC  = 32'd128,
    parameter int unsigned V_BACK  = 32'd33,
    parameter int unsigned V_DISP  = 32'd480,
    parameter int unsigned V_FRONT = 32'd10,
    parameter int unsigned V_SYNC  = 32'd2
) (
    input  logic        lcd_pclk,
    input  logic        rst,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        data_req,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic [15:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_BACK + H_DISP + H_FRONT + H_SYNC;
    localparam int unsigned V_TOTAL = V_BACK + V_DISP + V_FRONT + V_SYNC;

    localparam logic [10:0] C_H_LAST      = 11'(H_TOTAL - 32'd1);
    localparam logic [10:0] C_V_LAST      = 11'(V_TOTAL - 32'd1);
    localparam logic [10:0] C_H_ACT_BEG   = 11'(H_BACK);
    localparam logic [10:0] C_H_ACT_END   = 11'(H_BACK + H_DISP);
    localparam logic [10:0] C_H_REQ_BEG   = 11'(H_BACK - 32'd1);
    localparam logic [10:0] C_H_REQ_END   = 11'(H_BACK + H_DISP - 32'd1);
    localparam logic [10:0] C_V_ACT_BEG   = 11'(V_BACK);
    localparam logic [10:0] C_V_ACT_END   = 11'(V_BACK + V_DISP);
    localparam logic [10:0] C_H_SYNC_BEG  = 11'(H_TOTAL - H_SYNC);
    localparam logic [10:0] C_V_SYNC_BEG  = 11'(V_TOTAL - V_SYNC);

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_h_act;
    logic        w_h_req;
    logic        w_v_act;

    assign w_h_wrap = (r_h_cnt == C_H_LAST);
    assign w_v_wrap = (r_v_cnt == C_V_LAST);
    assign h_disp   = 11'(H_DISP);
    assign v_disp   = 11'(V_DISP);

    // Free-running line/frame counters; v advances only when h wraps.
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            r_h_cnt <= 11'd0;
            r_v_cnt <= 11'd0;
        end else if (w_h_wrap) begin
            r_h_cnt <= 11'd0;
            if (w_v_wrap) begin
                r_v_cnt <= 11'd0;
            end else begin
                r_v_cnt <= r_v_cnt + 11'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
            r_v_cnt <= r_v_cnt;
        end
    end

    // Window decode; the request window runs one clock ahead of the active window.
    always_comb begin
        w_h_act    = (r_h_cnt >= C_H_ACT_BEG) && (r_h_cnt < C_H_ACT_END);
        w_h_req    = (r_h_cnt >= C_H_REQ_BEG) && (r_h_cnt < C_H_REQ_END);
        w_v_act    = (r_v_cnt >= C_V_ACT_BEG) && (r_v_cnt < C_V_ACT_END);
        lcd_hs     = ~(r_h_cnt >= C_H_SYNC_BEG);
        lcd_vs     = ~(r_v_cnt >= C_V_SYNC_BEG);
        lcd_de     = w_h_act & w_v_act;
        data_req   = w_h_req & w_v_act;
        pixel_xpos = 11'd0;
        pixel_ypos = 11'd0;
        lcd_rgb    = 24'h000000;
        if (data_req) begin
            pixel_xpos = r_h_cnt - C_H_REQ_BEG;
        end else begin
            pixel_xpos = 11'd0;
        end
        if (w_v_act) begin
            pixel_ypos = r_v_cnt - C_V_ACT_BEG;
        end else begin
            pixel_ypos = 11'd0;
        end
        // Display stage returns colour one clock after the request, i.e. aligned to lcd_de.
        if (lcd_de) begin
            lcd_rgb = pixel_data;
        end else begin
            lcd_rgb = 24'h000000;
        end
    end

`ifdef LCD_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Counts completed frames (simultaneous h and v wrap), rolling over at 16 bits.
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
        end else if (w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule
